// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_port_arbiter: round-robin share of one memory channel among R/W ports   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module mem_port_arbiter #(
  parameter int RPORT  = 2,
  parameter int WPORT  = 1,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [RPORT-1:0]          co_re,
  input  logic [RPORT*ADDR_W-1:0]   co_raddr,
  input  logic [RPORT*LEN_W-1:0]    co_rlen,
  output logic [RPORT*DATA_W-1:0]   co_din,
  output logic [RPORT-1:0]          co_rack,
  input  logic [WPORT-1:0]          co_we,
  input  logic [WPORT*ADDR_W-1:0]   co_waddr,
  input  logic [WPORT*LEN_W-1:0]    co_wlen,
  input  logic [WPORT*DATA_W-1:0]   co_dout,
  output logic [WPORT-1:0]          co_wack,
  output logic                      m_re,
  output logic                      m_we,
  output logic [ADDR_W-1:0]         m_addr,
  output logic [LEN_W-1:0]          m_len,
  output logic [DATA_W-1:0]         m_wdata,
  input  logic [DATA_W-1:0]         m_rdata,
  input  logic                      m_rack,
  input  logic                      m_wack,
  output logic                      busy,
  output logic [7:0]                grant_idx
);

  localparam int N = RPORT + WPORT;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_ACK  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [7:0]              ptr_q, ptr_d;
  logic [7:0]              grant_q, grant_d;
  logic [7:0]              mask_idx_q, mask_idx_d;
  logic                    mask_vld_q, mask_vld_d;
  logic                    m_re_q, m_re_d;
  logic                    m_we_q, m_we_d;
  logic                    busy_q, busy_d;
  logic [ADDR_W-1:0]       m_addr_q, m_addr_d;
  logic [LEN_W-1:0]        m_len_q, m_len_d;
  logic [DATA_W-1:0]       m_wdata_q, m_wdata_d;
  logic [RPORT*DATA_W-1:0] co_din_q, co_din_d;
  logic [RPORT-1:0]        co_rack_q, co_rack_d;
  logic [WPORT-1:0]        co_wack_q, co_wack_d;

  logic [N-1:0]            req;
  logic [N-1:0]            elig;
  logic                    hit;
  logic [7:0]              sel;

  assign req = {co_we, co_re};

  // The port granted last is held off for the first idle cycle after its ack.
  always_comb begin
    elig = '0;
    for (int i = 0; i < N; i++) begin
      elig[i] = req[i] && !(mask_vld_q && (mask_idx_q == 8'(i)));
    end
  end

  // Second pass overrides the first: lowest eligible index at or above ptr wins,
  // otherwise the lowest eligible index below ptr (wrap-around).
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (elig[i] && (8'(i) < ptr_q)) begin
        hit = 1'b1;
        sel = 8'(i);
      end
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (elig[i] && (8'(i) >= ptr_q)) begin
        hit = 1'b1;
        sel = 8'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    mask_idx_d = mask_idx_q;
    mask_vld_d = mask_vld_q;
    m_re_d     = m_re_q;
    m_we_d     = m_we_q;
    busy_d     = busy_q;
    m_addr_d   = m_addr_q;
    m_len_d    = m_len_q;
    m_wdata_d  = m_wdata_q;
    co_din_d   = co_din_q;
    co_rack_d  = '0;
    co_wack_d  = '0;
    case (state_q)
      S_IDLE: begin
        mask_vld_d = 1'b0;
        if (hit) begin
          grant_d = sel;
          busy_d  = 1'b1;
          for (int i = 0; i < RPORT; i++) begin
            if (sel == 8'(i)) begin
              m_addr_d = co_raddr[i*ADDR_W +: ADDR_W];
              m_len_d  = co_rlen[i*LEN_W +: LEN_W];
              m_re_d   = 1'b1;
              state_d  = S_RD;
            end
          end
          for (int j = 0; j < WPORT; j++) begin
            if (sel == 8'(RPORT + j)) begin
              m_addr_d  = co_waddr[j*ADDR_W +: ADDR_W];
              m_len_d   = co_wlen[j*LEN_W +: LEN_W];
              m_wdata_d = co_dout[j*DATA_W +: DATA_W];
              m_we_d    = 1'b1;
              state_d   = S_WR;
            end
          end
        end
      end
      S_RD: begin
        if (m_rack) begin
          m_re_d  = 1'b0;
          busy_d  = 1'b0;
          state_d = S_ACK;
          for (int i = 0; i < RPORT; i++) begin
            if (grant_q == 8'(i)) begin
              co_din_d[i*DATA_W +: DATA_W] = m_rdata;
              co_rack_d[i]                 = 1'b1;
            end
          end
        end
      end
      S_WR: begin
        if (m_wack) begin
          m_we_d  = 1'b0;
          busy_d  = 1'b0;
          state_d = S_ACK;
          for (int j = 0; j < WPORT; j++) begin
            if (grant_q == 8'(RPORT + j)) co_wack_d[j] = 1'b1;
          end
        end
      end
      S_ACK: begin
        ptr_d      = (grant_q == 8'(N - 1)) ? 8'd0 : grant_q + 8'd1;
        mask_idx_d = grant_q;
        mask_vld_d = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      grant_q    <= '0;
      mask_idx_q <= '0;
      mask_vld_q <= 1'b0;
      m_re_q     <= 1'b0;
      m_we_q     <= 1'b0;
      busy_q     <= 1'b0;
      m_addr_q   <= '0;
      m_len_q    <= '0;
      m_wdata_q  <= '0;
      co_din_q   <= '0;
      co_rack_q  <= '0;
      co_wack_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      mask_idx_q <= mask_idx_d;
      mask_vld_q <= mask_vld_d;
      m_re_q     <= m_re_d;
      m_we_q     <= m_we_d;
      busy_q     <= busy_d;
      m_addr_q   <= m_addr_d;
      m_len_q    <= m_len_d;
      m_wdata_q  <= m_wdata_d;
      co_din_q   <= co_din_d;
      co_rack_q  <= co_rack_d;
      co_wack_q  <= co_wack_d;
    end
  end

  assign m_re      = m_re_q;
  assign m_we      = m_we_q;
  assign m_addr    = m_addr_q;
  assign m_len     = m_len_q;
  assign m_wdata   = m_wdata_q;
  assign co_din    = co_din_q;
  assign co_rack   = co_rack_q;
  assign co_wack   = co_wack_q;
  assign busy      = busy_q;
  assign grant_idx = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_port_arbiter: directed and randomized bench for mem_port_arbiter     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_mem_port_arbiter;

  localparam int RPORT  = 2;
  localparam int WPORT  = 1;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 32;
  localparam int LEN_W  = 2;
  localparam int N      = RPORT + WPORT;

  localparam int M_IDLE  = 0;
  localparam int M_IDLE1 = 1;
  localparam int M_BUSY  = 2;
  localparam int M_ACK   = 3;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic [RPORT-1:0]        co_re = '0;
  logic [RPORT*ADDR_W-1:0] co_raddr = '0;
  logic [RPORT*LEN_W-1:0]  co_rlen = '0;
  logic [RPORT*DATA_W-1:0] co_din;
  logic [RPORT-1:0]        co_rack;
  logic [WPORT-1:0]        co_we = '0;
  logic [WPORT*ADDR_W-1:0] co_waddr = '0;
  logic [WPORT*LEN_W-1:0]  co_wlen = '0;
  logic [WPORT*DATA_W-1:0] co_dout = '0;
  logic [WPORT-1:0]        co_wack;
  logic                    m_re, m_we, busy;
  logic [ADDR_W-1:0]       m_addr;
  logic [LEN_W-1:0]        m_len;
  logic [DATA_W-1:0]       m_wdata;
  logic [DATA_W-1:0]       m_rdata = '0;
  logic                    m_rack = 1'b0;
  logic                    m_wack = 1'b0;
  logic [7:0]              grant_idx;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .RPORT(RPORT), .WPORT(WPORT), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst(rst),
    .co_re(co_re), .co_raddr(co_raddr), .co_rlen(co_rlen), .co_din(co_din), .co_rack(co_rack),
    .co_we(co_we), .co_waddr(co_waddr), .co_wlen(co_wlen), .co_dout(co_dout), .co_wack(co_wack),
    .m_re(m_re), .m_we(m_we), .m_addr(m_addr), .m_len(m_len), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_rack(m_rack), .m_wack(m_wack),
    .busy(busy), .grant_idx(grant_idx)
  );

  function automatic logic [63:0] mem_fn(input logic [31:0] a);
    return (a == 32'h100) ? 64'hDEADBEEF_01234567 : {a ^ 32'h1357_9BDF, ~a};
  endfunction

  // Memory model: acks `lat` cycles after seeing a request; optional stray acks of the wrong kind.
  int lat = 0;
  int cnt = 0;
  bit spur = 1'b0;
  always begin
    @(posedge clk);
    #1;
    m_rack = 1'b0;
    m_wack = 1'b0;
    if (m_re || m_we) begin
      if (cnt >= lat) begin
        cnt = 0;
        if (m_re) begin
          m_rack  = 1'b1;
          m_rdata = mem_fn(m_addr);
        end else begin
          m_wack = 1'b1;
        end
      end else begin
        cnt++;
        if (spur) begin
          if (m_re) m_wack = 1'($urandom_range(0, 1));
          else begin
            m_rack  = 1'($urandom_range(0, 1));
            m_rdata = {$urandom, $urandom};
          end
        end
      end
    end else begin
      cnt = 0;
      if (spur) begin
        m_rack  = 1'($urandom_range(0, 1));
        m_wack  = 1'($urandom_range(0, 1));
        m_rdata = {$urandom, $urandom};
      end
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model state: transaction phase, RR pointer, last winner, per-port read data.
  int                mode, mptr, last, cur, cur_lat, busy_cnt, ev_ack, ev_grant;
  logic [ADDR_W-1:0] e_addr;
  logic [LEN_W-1:0]  e_len;
  logic [DATA_W-1:0] e_wdata;
  logic [DATA_W-1:0] din_m [RPORT];

  function automatic logic [RPORT*DATA_W-1:0] din_flat();
    logic [RPORT*DATA_W-1:0] v;
    for (int i = 0; i < RPORT; i++) v[i*DATA_W +: DATA_W] = din_m[i];
    return v;
  endfunction

  task automatic model_reset();
    mode     = M_IDLE;
    mptr     = 0;
    last     = 0;
    ev_ack   = -1;
    ev_grant = -1;
    for (int i = 0; i < RPORT; i++) din_m[i] = '0;
  endtask

  // One clock: predict from the requests presented to this edge, then check after it.
  task automatic step();
    logic [N-1:0]     rq;
    logic [RPORT-1:0] er;
    logic [WPORT-1:0] ew;
    int w, idx, pm;
    rq = {co_we, co_re};
    pm = mode;
    w  = -1;
    if (pm == M_IDLE || pm == M_IDLE1) begin
      for (int k = 0; k < N; k++) begin
        idx = (mptr + k) % N;
        if (w < 0 && rq[idx] && !(pm == M_IDLE1 && idx == last)) w = idx;
      end
      if (w >= 0) begin
        if (w < RPORT) begin
          e_addr = co_raddr[w*ADDR_W +: ADDR_W];
          e_len  = co_rlen[w*LEN_W +: LEN_W];
        end else begin
          e_addr  = co_waddr[(w-RPORT)*ADDR_W +: ADDR_W];
          e_len   = co_wlen[(w-RPORT)*LEN_W +: LEN_W];
          e_wdata = co_dout[(w-RPORT)*DATA_W +: DATA_W];
        end
        cur_lat = lat;
      end
    end
    ev_ack   = -1;
    ev_grant = -1;
    @(posedge clk);
    #1;
    if (pm == M_IDLE || pm == M_IDLE1) begin
      chk("idle_rack", co_rack, 0);
      chk("idle_wack", co_wack, 0);
      if (w >= 0) begin
        chk("grant_idx", grant_idx, w);
        chk("grant_re", m_re, (w < RPORT));
        chk("grant_we", m_we, (w >= RPORT));
        chk("grant_busy", busy, 1);
        chk("grant_addr", m_addr, e_addr);
        chk("grant_len", m_len, e_len);
        if (w >= RPORT) chk("grant_wdata", m_wdata, e_wdata);
        cur      = w;
        busy_cnt = 0;
        mode     = M_BUSY;
        ev_grant = w;
      end else begin
        chk("nogrant_re", m_re, 0);
        chk("nogrant_we", m_we, 0);
        chk("nogrant_busy", busy, 0);
        mode = M_IDLE;
      end
    end else if (pm == M_BUSY) begin
      busy_cnt++;
      if (busy_cnt == cur_lat + 1) begin
        er = '0;
        ew = '0;
        if (cur < RPORT) begin
          er[cur]    = 1'b1;
          din_m[cur] = mem_fn(e_addr);
        end else begin
          ew[cur-RPORT] = 1'b1;
        end
        chk("ack_rack", co_rack, er);
        chk("ack_wack", co_wack, ew);
        chk("ack_busy", busy, 0);
        chk("ack_re", m_re, 0);
        chk("ack_we", m_we, 0);
        chk("ack_din", co_din, din_flat());
        mptr   = (cur + 1) % N;
        last   = cur;
        mode   = M_ACK;
        ev_ack = cur;
      end else begin
        chk("wait_rack", co_rack, 0);
        chk("wait_wack", co_wack, 0);
        chk("wait_busy", busy, 1);
        chk("wait_re", m_re, (cur < RPORT));
        chk("wait_we", m_we, (cur >= RPORT));
        chk("wait_addr", m_addr, e_addr);
        chk("wait_len", m_len, e_len);
        chk("wait_gidx", grant_idx, cur);
      end
    end else begin
      chk("post_rack", co_rack, 0);
      chk("post_wack", co_wack, 0);
      chk("post_busy", busy, 0);
      chk("post_re", m_re, 0);
      chk("post_we", m_we, 0);
      chk("post_din", co_din, din_flat());
      mode = M_IDLE1;
    end
  endtask

  task automatic do_reset();
    rst   = 1'b0;
    co_re = '0;
    co_we = '0;
    spur  = 1'b0;
    lat   = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_m_re", m_re, 0);
    chk("rst_m_we", m_we, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_len", m_len, 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_co_din", co_din, 0);
    chk("rst_co_rack", co_rack, 0);
    chk("rst_co_wack", co_wack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_idx, 0);
    rst = 1'b1;
    model_reset();
  endtask

  logic [7:0]   gseq [6];
  int           ng;
  int           hold [N];
  int           h;
  logic [N-1:0] rqv;

  initial begin
    // reset, then idle with no requests
    do_reset();
    repeat (10) step();

    // single read, 5-cycle memory latency
    do_reset();
    co_raddr = {32'h0000_0ABC, 32'h0000_0100};
    co_rlen  = {2'd1, 2'd3};
    co_re    = 2'b01;
    lat      = 5;
    for (int t = 0; t < 30; t++) begin
      step();
      if (ev_ack >= 0) break;
    end
    chk("rd_rack", co_rack, 2'b01);
    chk("rd_din0", co_din[63:0], 64'hDEADBEEF_01234567);
    chk("rd_din1", co_din[127:64], 0);
    co_re = '0;
    step();
    chk("rd_rack_width", co_rack, 0);
    repeat (3) step();

    // round-robin with all requests held and immediate acks
    do_reset();
    for (int i = 0; i < 6; i++) gseq[i] = 8'hFF;
    ng    = 0;
    co_re = 2'b11;
    co_we = 1'b1;
    lat   = 0;
    for (int t = 0; t < 40 && ng < 6; t++) begin
      step();
      if (ev_grant >= 0) begin
        gseq[ng] = grant_idx;
        ng++;
      end
    end
    for (int i = 0; i < 6; i++) chk("rr_seq", gseq[i], i % 3);
    co_re = '0;
    co_we = '0;
    repeat (6) step();

    // re-request suppression: port 1 keeps asking through the first idle cycle
    do_reset();
    co_re = 2'b10;
    lat   = 0;
    for (int t = 0; t < 20; t++) begin
      step();
      if (ev_ack >= 0) break;
    end
    step();
    step();
    co_re = '0;
    repeat (5) step();
    chk("rereq_re", m_re, 0);

    // write path with stray read acks during the write
    do_reset();
    co_waddr = 32'h200;
    co_dout  = 64'h55AA;
    co_wlen  = 2'd2;
    co_we    = 1'b1;
    lat      = 3;
    spur     = 1'b1;
    step();
    chk("wr_m_we", m_we, 1);
    chk("wr_wdata", m_wdata, 64'h55AA);
    for (int t = 0; t < 20; t++) begin
      step();
      if (ev_ack >= 0) break;
    end
    chk("wr_wack", co_wack, 1);
    chk("wr_rack", co_rack, 0);
    co_we = '0;
    spur  = 1'b0;
    repeat (3) step();

    // reset in the middle of a read, then port 1 wins from ptr 0
    do_reset();
    co_raddr = {32'h0000_0444, 32'h0000_0333};
    co_re    = 2'b01;
    lat      = 20;
    repeat (3) step();
    #3;
    rst = 1'b0;
    #1;
    chk("midrst_re", m_re, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_rack", co_rack, 0);
    @(posedge clk);
    #1;
    chk("midrst_rack2", co_rack, 0);
    rst   = 1'b1;
    co_re = 2'b10;
    lat   = 1;
    model_reset();
    step();
    chk("midrst_regrant", grant_idx, 1);
    for (int t = 0; t < 10; t++) begin
      step();
      if (ev_ack >= 0) break;
    end
    co_re = '0;
    repeat (3) step();

    // randomized traffic against the model
    do_reset();
    spur = 1'b1;
    for (int p = 0; p < N; p++) hold[p] = 0;
    for (int it = 0; it < 1500; it++) begin
      if (mode == M_IDLE || mode == M_IDLE1) lat = $urandom_range(0, 4);
      co_raddr = {$urandom, $urandom};
      co_rlen  = 4'($urandom);
      co_waddr = $urandom;
      co_wlen  = 2'($urandom);
      co_dout  = {$urandom, $urandom};
      rqv = {co_we, co_re};
      for (int p = 0; p < N; p++) begin
        if (p == ev_ack) begin
          h = $urandom_range(0, 2);
          if (h == 0) rqv[p] = 1'b0;
          else hold[p] = h;
        end else if (hold[p] > 0) begin
          hold[p]--;
          if (hold[p] == 0) rqv[p] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          rqv[p] = ~rqv[p];
        end
      end
      {co_we, co_re} = rqv;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
